// File: rtl/axis_fifo.sv
// AXI4-Stream FIFO carrying the full sideband on a single clock.
// Optional store-and-forward mode discards packets that cannot fit.
module axis_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int ID_WIDTH    = 4,
    parameter int DEST_WIDTH  = 4,
    parameter int USER_WIDTH  = 16,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_tstrb,
    input  logic [DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [ID_WIDTH-1:0]       s_tid,
    input  logic [DEST_WIDTH-1:0]     s_tdest,
    input  logic [USER_WIDTH-1:0]     s_tuser,
    input  logic                      s_tlast,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_tstrb,
    output logic [DATA_WIDTH/8-1:0]   m_tkeep,
    output logic [ID_WIDTH-1:0]       m_tid,
    output logic [DEST_WIDTH-1:0]     m_tdest,
    output logic [USER_WIDTH-1:0]     m_tuser,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      drop
);

    localparam int ADDR_WIDTH  = $clog2(DEPTH);
    localparam int PTR_WIDTH   = ADDR_WIDTH + 1;
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int ENTRY_WIDTH = DATA_WIDTH + 2 * STRB_WIDTH + ID_WIDTH
                               + DEST_WIDTH + USER_WIDTH + 1;

    typedef enum logic {
        NORMAL,
        DROP
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr_n;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr_n;
    logic [PTR_WIDTH-1:0]   wr_commit;
    logic [PTR_WIDTH-1:0]   wr_commit_n;
    logic                   s_ready_r;
    logic                   s_ready_n;
    logic                   drop_r;
    logic                   drop_n;
    logic                   full;
    logic                   m_valid;
    logic                   wr_en;
    logic                   rd_en;
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic [ENTRY_WIDTH-1:0] rd_entry;

    function automatic logic is_full(
        input logic [PTR_WIDTH-1:0] w,
        input logic [PTR_WIDTH-1:0] r
    );
        return (w[ADDR_WIDTH] != r[ADDR_WIDTH]) &&
               (w[ADDR_WIDTH-1:0] == r[ADDR_WIDTH-1:0]);
    endfunction

    assign full = is_full(wr_ptr, rd_ptr);

    // Packet mode only exposes words up to the last committed tlast.
    assign m_valid = (PACKET_MODE != 0) ? (rd_ptr != wr_commit)
                                        : (wr_ptr != rd_ptr);

    assign wr_en = s_tvalid && s_ready_r && (state == NORMAL);
    assign rd_en = m_valid && m_tready;

    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr + PTR_WIDTH'(wr_en);
        rd_ptr_n    = rd_ptr + PTR_WIDTH'(rd_en);
        wr_commit_n = wr_commit;
        drop_n      = 1'b0;
        if (wr_en && s_tlast) begin
            wr_commit_n = wr_ptr_n;
        end
        unique case (state)
            NORMAL: begin
                // Full with nothing committed: the packet can never fit.
                if ((PACKET_MODE != 0) && full && (rd_ptr == wr_commit)) begin
                    state_n  = DROP;
                    wr_ptr_n = wr_commit;
                end
            end
            DROP: begin
                if (s_tvalid && s_ready_r && s_tlast) begin
                    state_n = NORMAL;
                    drop_n  = 1'b1;
                end
            end
        endcase
        s_ready_n = (state_n == DROP) || !is_full(wr_ptr_n, rd_ptr_n);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= NORMAL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_commit <= '0;
            s_ready_r <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            wr_commit <= wr_commit_n;
            s_ready_r <= s_ready_n;
            drop_r    <= drop_n;
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_tdata, s_tstrb, s_tkeep, s_tid,
                                            s_tdest, s_tuser, s_tlast};
        end
    end

    assign rd_entry = mem[rd_ptr[ADDR_WIDTH-1:0]];

    assign {m_tdata, m_tstrb, m_tkeep, m_tid,
            m_tdest, m_tuser, m_tlast} = rd_entry;

    assign m_tvalid = m_valid;
    assign s_tready = s_ready_r;
    assign count    = wr_ptr - rd_ptr;
    assign drop     = drop_r;

endmodule

// File: tb/tb_axis_fifo.sv
// Randomised bench for axis_fifo: one cut-through and one packet-mode
// instance, each compared against a queue-based reference model.
module tb_axis_fifo;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic [3:0]  id;
        logic [3:0]  dest;
        logic [15:0] user;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic [3:0]  s_tkeep;
    logic [3:0]  s_tid;
    logic [3:0]  s_tdest;
    logic [15:0] s_tuser;
    logic        s_tlast;

    logic        ct_s_tvalid, ct_s_tready, ct_m_tvalid, ct_m_tready;
    logic [31:0] ct_m_tdata;
    logic [3:0]  ct_m_tstrb, ct_m_tkeep, ct_m_tid, ct_m_tdest;
    logic [15:0] ct_m_tuser;
    logic        ct_m_tlast, ct_drop;
    logic [4:0]  ct_count;

    logic        pk_s_tvalid, pk_s_tready, pk_m_tvalid, pk_m_tready;
    logic [31:0] pk_m_tdata;
    logic [3:0]  pk_m_tstrb, pk_m_tkeep, pk_m_tid, pk_m_tdest;
    logic [15:0] pk_m_tuser;
    logic        pk_m_tlast, pk_drop;
    logic [4:0]  pk_count;

    axis_fifo #(.DEPTH(16), .PACKET_MODE(0)) u_ct (
        .aclk(clk), .areset(areset),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tvalid(ct_s_tvalid), .s_tready(ct_s_tready),
        .m_tdata(ct_m_tdata), .m_tstrb(ct_m_tstrb), .m_tkeep(ct_m_tkeep),
        .m_tid(ct_m_tid), .m_tdest(ct_m_tdest), .m_tuser(ct_m_tuser),
        .m_tlast(ct_m_tlast), .m_tvalid(ct_m_tvalid), .m_tready(ct_m_tready),
        .count(ct_count), .drop(ct_drop)
    );

    axis_fifo #(.DEPTH(16), .PACKET_MODE(1)) u_pk (
        .aclk(clk), .areset(areset),
        .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
        .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
        .s_tlast(s_tlast), .s_tvalid(pk_s_tvalid), .s_tready(pk_s_tready),
        .m_tdata(pk_m_tdata), .m_tstrb(pk_m_tstrb), .m_tkeep(pk_m_tkeep),
        .m_tid(pk_m_tid), .m_tdest(pk_m_tdest), .m_tuser(pk_m_tuser),
        .m_tlast(pk_m_tlast), .m_tvalid(pk_m_tvalid), .m_tready(pk_m_tready),
        .count(pk_count), .drop(pk_drop)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    word_t ctq[$];
    word_t pk_out[$];
    word_t pk_pend[$];
    bit    pk_dropping;
    bit    pk_drop_exp;
    int    pk_drops;
    int    pk_delivered;

    task automatic check(input string tag, input logic [95:0] got,
                         input logic [95:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic word_t rnd_word();
        word_t w;
        w.data = $urandom;
        w.strb = 4'($urandom);
        w.keep = 4'($urandom);
        w.id   = 4'($urandom);
        w.dest = 4'($urandom);
        w.user = 16'($urandom);
        w.last = 1'($urandom);
        return w;
    endfunction

    function automatic word_t ct_obs();
        return {ct_m_tdata, ct_m_tstrb, ct_m_tkeep, ct_m_tid,
                ct_m_tdest, ct_m_tuser, ct_m_tlast};
    endfunction

    function automatic word_t pk_obs();
        return {pk_m_tdata, pk_m_tstrb, pk_m_tkeep, pk_m_tid,
                pk_m_tdest, pk_m_tuser, pk_m_tlast};
    endfunction

    task automatic drive(input word_t w);
        {s_tdata, s_tstrb, s_tkeep, s_tid, s_tdest, s_tuser, s_tlast} = w;
    endtask

    // One clock of the cut-through instance; called #1 after a rising edge.
    task automatic ct_cycle(input bit sv, input bit mr, input word_t w,
                            output bit wf);
        bit rf;
        check("ct_count", 96'(ct_count), 96'(ctq.size()));
        check("ct_valid", 96'(ct_m_tvalid), 96'(ctq.size() != 0));
        check("ct_ready", 96'(ct_s_tready), 96'(ctq.size() < 16));
        if (ctq.size() != 0) check("ct_word", 96'(ct_obs()), 96'(ctq[0]));
        ct_s_tvalid = sv;
        ct_m_tready = mr;
        drive(w);
        wf = sv && ct_s_tready;
        rf = ct_m_tvalid && mr;
        @(posedge clk);
        #1;
        if (rf) void'(ctq.pop_front());
        if (wf) ctq.push_back(w);
    endtask

    // One clock of the packet-mode instance against a store-and-forward model.
    task automatic pk_cycle(input bit sv, input bit mr, input word_t w,
                            output bit wf);
        bit rf;
        int stored;
        int out_pre;
        stored  = pk_out.size() + pk_pend.size();
        out_pre = pk_out.size();
        check("pk_count", 96'(pk_count), 96'(stored));
        check("pk_valid", 96'(pk_m_tvalid), 96'(out_pre != 0));
        check("pk_ready", 96'(pk_s_tready), 96'(pk_dropping || stored < 16));
        check("pk_drop", 96'(pk_drop), 96'(pk_drop_exp));
        if (out_pre != 0) check("pk_word", 96'(pk_obs()), 96'(pk_out[0]));
        if (pk_drop) pk_drops++;
        pk_s_tvalid = sv;
        pk_m_tready = mr;
        drive(w);
        wf = sv && pk_s_tready;
        rf = pk_m_tvalid && mr;
        @(posedge clk);
        #1;
        pk_drop_exp = 1'b0;
        if (rf && pk_out.size() != 0) begin
            void'(pk_out.pop_front());
            pk_delivered++;
        end
        if (pk_dropping) begin
            if (wf && w.last) begin
                pk_dropping = 1'b0;
                pk_drop_exp = 1'b1;
            end
        end else if (stored == 16 && out_pre == 0) begin
            pk_dropping = 1'b1;
            pk_pend.delete();
        end else if (wf) begin
            pk_pend.push_back(w);
            if (w.last) begin
                foreach (pk_pend[i]) pk_out.push_back(pk_pend[i]);
                pk_pend.delete();
            end
        end
    endtask

    task automatic pk_packet(input int len, input bit stall, input word_t tmpl);
        int    i = 0;
        int    guard = 0;
        bit    wf;
        bit    sv;
        bit    mr;
        word_t w;
        while (i < len && guard < 400) begin
            w      = tmpl;
            w.data = tmpl.data + 32'(i);
            w.last = (i == len - 1);
            sv     = stall ? ($urandom % 4 != 0) : 1'b1;
            mr     = stall ? ($urandom % 3 != 0) : 1'b1;
            pk_cycle(sv, mr, w, wf);
            if (wf) i++;
            guard++;
        end
        check("pk_sent", 96'(i), 96'(len));
    endtask

    task automatic pk_idle(input int n);
        bit wf;
        for (int i = 0; i < n; i++) pk_cycle(1'b0, 1'b1, rnd_word(), wf);
    endtask

    task automatic do_reset();
        areset      = 1'b1;
        ct_s_tvalid = 1'b0;
        pk_s_tvalid = 1'b0;
        ct_m_tready = 1'b0;
        pk_m_tready = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;
        ctq.delete();
        pk_out.delete();
        pk_pend.delete();
        pk_dropping = 1'b0;
        pk_drop_exp = 1'b0;
        check("rst_ct_ready", 96'(ct_s_tready), 96'(0));
        check("rst_ct_valid", 96'(ct_m_tvalid), 96'(0));
        check("rst_ct_count", 96'(ct_count), 96'(0));
        check("rst_pk_ready", 96'(pk_s_tready), 96'(0));
        check("rst_pk_valid", 96'(pk_m_tvalid), 96'(0));
        check("rst_pk_drop", 96'(pk_drop), 96'(0));
        @(posedge clk);
        #1;
        check("rst_ct_ready_up", 96'(ct_s_tready), 96'(1));
        check("rst_pk_ready_up", 96'(pk_s_tready), 96'(1));
    endtask

    initial begin
        bit    wf;
        int    sent;
        int    guard;
        word_t w;
        areset = 1'b1;
        drive('0);
        do_reset();

        // Fill to full with the reader stalled, then drain in order.
        for (int i = 0; i < 16; i++) begin
            w = rnd_word();
            w.data = 32'(i);
            ct_cycle(1'b1, 1'b0, w, wf);
        end
        check("fill_count", 96'(ct_count), 96'(16));
        check("fill_ready", 96'(ct_s_tready), 96'(0));
        check("fill_head", 96'(ct_m_tdata), 96'(0));
        ct_cycle(1'b1, 1'b1, rnd_word(), wf);
        check("full_rw_nowrite", 96'(wf), 96'(0));
        for (int i = 0; i < 16; i++) ct_cycle(1'b0, 1'b1, rnd_word(), wf);

        // Steady state at eight entries with concurrent read and write.
        for (int i = 0; i < 8; i++) ct_cycle(1'b1, 1'b0, rnd_word(), wf);
        for (int i = 0; i < 20; i++) begin
            ct_cycle(1'b1, 1'b1, rnd_word(), wf);
            check("steady_count", 96'(ct_count), 96'(8));
        end
        for (int i = 0; i < 10; i++) ct_cycle(1'b0, 1'b1, rnd_word(), wf);

        // Reset while holding five words.
        for (int i = 0; i < 5; i++) ct_cycle(1'b1, 1'b0, rnd_word(), wf);
        do_reset();
        for (int i = 0; i < 3; i++) ct_cycle(1'b0, 1'b1, rnd_word(), wf);
        ct_cycle(1'b1, 1'b0, rnd_word(), wf);
        for (int i = 0; i < 3; i++) ct_cycle(1'b0, 1'b1, rnd_word(), wf);

        // Random stalls on both sides, 1000 words.
        sent  = 0;
        guard = 0;
        while ((sent < 1000 || ctq.size() != 0) && guard < 20000) begin
            ct_cycle(sent < 1000 && ($urandom % 4 != 0),
                     $urandom % 3 != 0, rnd_word(), wf);
            if (wf) sent++;
            guard++;
        end
        check("rand_sent", 96'(sent), 96'(1000));
        check("rand_left", 96'(ctq.size()), 96'(0));
        ct_s_tvalid = 1'b0;
        check("ct_no_drop", 96'(ct_drop), 96'(0));

        // Packet mode: one 4-word packet with fixed sideband.
        w      = '0;
        w.data = 32'hA0;
        w.strb = 4'hF;
        w.keep = 4'hF;
        w.id   = 4'd3;
        w.dest = 4'd5;
        w.user = 16'hBEEF;
        pk_delivered = 0;
        pk_packet(4, 1'b0, w);
        pk_idle(6);
        check("pk4_delivered", 96'(pk_delivered), 96'(4));

        // Oversize 20-word packet followed by a 2-word packet.
        pk_drops     = 0;
        pk_delivered = 0;
        w.data       = 32'h100;
        pk_packet(20, 1'b0, w);
        w.data = 32'h200;
        pk_packet(2, 1'b0, w);
        pk_idle(6);
        check("pk_drop_pulses", 96'(pk_drops), 96'(1));
        check("pk2_delivered", 96'(pk_delivered), 96'(2));

        // Random packet lengths with stalls, some oversize.
        for (int p = 0; p < 60; p++) begin
            pk_packet(($urandom % 10 == 0) ? 20 : int'($urandom_range(1, 8)),
                      1'b1, rnd_word());
        end
        pk_idle(40);
        check("pk_rand_left", 96'(pk_out.size() + pk_pend.size()), 96'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axis_fifo.md
# axis_fifo

Parametrised AXI4-Stream FIFO carrying the full stream sideband (tdata, tstrb, tkeep, tid, tdest, tuser, tlast) between an upstream master and a downstream slave on one clock. In cut-through mode it buffers and decouples backpressure. In packet mode it becomes store-and-forward: nothing is released until a whole packet (through tlast) is stored, and packets larger than the buffer are dropped. It sits between bus-facing stream sources and the core's stream consumers wherever elastic buffering or packet framing is needed.

## Interface
- DATA_WIDTH, 32, tdata bits; multiple of 8; STRB_WIDTH = KEEP_WIDTH = DATA_WIDTH/8
- ID_WIDTH, 4, tid bits
- DEST_WIDTH, 4, tdest bits
- USER_WIDTH, 16, tuser bits
- DEPTH, 16, entries; power of two, >= 2; ADDR_WIDTH = log2(DEPTH)
- PACKET_MODE, 0, 0 = cut-through, 1 = store-and-forward with oversize drop
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  synchronous, active-high reset
- s_tdata / s_tstrb / s_tkeep  in  DATA_WIDTH / STRB_WIDTH / KEEP_WIDTH  slave payload
- s_tid / s_tdest / s_tuser  in  ID_WIDTH / DEST_WIDTH / USER_WIDTH  slave sideband
- s_tlast  in  1  end of packet
- s_tvalid  in  1  slave valid
- s_tready  out  1  slave ready
- m_tdata / m_tstrb / m_tkeep  out  as slave  master payload
- m_tid / m_tdest / m_tuser  out  as slave  master sideband
- m_tlast  out  1  end of packet
- m_tvalid  out  1  master valid
- m_tready  in  1  master ready
- count  out  ADDR_WIDTH+1  stored words, 0..DEPTH
- drop  out  1  one-cycle pulse when an oversize packet is discarded (PACKET_MODE=1)

## Operation
- Storage: DEPTH-entry flop array, one entry = all payload and sideband fields; pointers wr_ptr, rd_ptr are ADDR_WIDTH+1 bits with a wrap bit. Empty when equal; full when the low bits match and the wrap bits differ.
- Write on s_tvalid && s_tready; read on m_tvalid && m_tready; both may occur in the same cycle.
- s_tready = !full, registered. It never depends combinationally on m_tready: a full FIFO with a simultaneous read still shows s_tready=0 that cycle.
- m_* outputs are driven from mem[rd_ptr]. There is no combinational path from any s_* input to any m_* output.
- Cut-through: m_tvalid = !empty.
- Packet mode: wr_commit pointer advances to wr_ptr+1 on a write with s_tlast=1; m_tvalid = (rd_ptr != wr_commit).
- Oversize packet in packet mode: the FIFO is full and rd_ptr == wr_commit (no complete packet to drain). Then:
  - enter DROP: wr_ptr <= wr_commit;
  - s_tready forced 1; incoming words are discarded;
  - on the accepted word with s_tlast=1, pulse drop and return to NORMAL.
- States: NORMAL, DROP. DROP exists only when PACKET_MODE=1. A word with s_tlast=1 that arrives exactly as the FIFO fills is stored and committed, not dropped.
- count = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
- Field values are passed through unmodified; the block imposes no tkeep or tstrb rules.

## Timing
- Reset values: pointers and wr_commit 0, state NORMAL, m_tvalid 0, s_tready 0, count 0, drop 0. s_tready rises in the first cycle after areset falls. Reset mid-packet discards all contents with no drop pulse.
- Cut-through latency: a word accepted at edge k is presented with m_tvalid=1 in the cycle following edge k.
- Packet-mode latency: the first word becomes valid in the cycle following the edge that accepts its tlast word.
- s_tready rises in the cycle after the read that makes the FIFO non-full.
- Full throughput: one word per cycle sustained when neither side stalls.
- m_* outputs remain stable while m_tvalid && !m_tready.

## Test plan
- DEPTH=16, cut-through: write 0x00..0x0F back-to-back with m_tready=0. Required: s_tready falls after the 16th word, count=16, m_tdata=0x00. Then m_tready=1 drains 0x00..0x0F in order, one per cycle.
- Simultaneous read/write at count=8 for 20 cycles. Required: count holds at 8, data order preserved, pointers wrap correctly.
- Packet mode: 4-word packet with tid=3, tdest=5, tuser=0xBEEF, with tlast on word 4. Required: m_tvalid stays 0 until the cycle after word 4 is accepted; all sideband fields match; m_tlast=1 only on word 4.
- Packet mode, DEPTH=16: a 20-word packet, followed by a 2-word packet. Required: drop pulses once when word 20 is accepted, the 20-word packet never appears, and the 2-word packet is delivered intact.
- Assert areset for one cycle while holding 5 words. Required: m_tvalid=0, count=0, s_tready=0 during reset and 1 the next cycle; no stale data is output afterwards.
- Random valid/ready stall pattern, 1000 words. Required: output sequence equals input sequence, and m_* outputs stay stable throughout every stall.
